// File: rtl/exins_responder_pkg.sv
// Shared definitions for the exIns instruction-memory responder.
//   INS_NOP     : word returned for misaligned / out-of-range fetches
//   LAT_MAX     : largest supported response latency
//   ins_rsp_t   : payload carried down the response pipeline
//   addr_width(): log2 of the word depth (word-index width)
package exins_responder_pkg;

  localparam logic [31:0] INS_NOP = 32'h0000_0013;
  localparam int unsigned LAT_MAX = 8;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } ins_rsp_t;

  function automatic int unsigned addr_width(input int unsigned depth);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(depth)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/exins_delay_line.sv
// Fixed-depth shift register with a per-stage valid bit.
//   clk, rst  : clock, asynchronous active-high reset (clears valid and data)
//   flush     : synchronous; clears every valid bit and drops the incoming entry
//   in_valid  : entry present at the input this cycle
//   in_data   : entry payload
//   out_valid : valid bit of the last stage
//   out_data  : payload of the last stage (holds its last value while invalid)
module exins_delay_line #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] dat [DEPTH];

  // Payload only moves along with a valid bit, so an empty stage keeps the
  // last delivered value and the output data holds between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) dat[i] <= '0;
    end else begin
      if (flush) begin
        vld <= '0;
      end else begin
        vld[0] <= in_valid;
        for (int unsigned i = 1; i < DEPTH; i++) vld[i] <= vld[i-1];
      end
      if (in_valid && !flush) dat[0] <= in_data;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (vld[i-1] && !flush) dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/exins_responder.sv
// Instruction-memory end of the exIns fetch interface. Fully pipelined,
// one fetch per cycle, response exactly LAT cycles after the request edge.
//   clk, rst     : clock, asynchronous active-high reset (array not reset)
//   exIns_ren    : fetch strobe;  exIns_addr : fetch byte address
//   exIns_valid  : response valid; exIns_data : instruction; exIns_err : bad address
//   flush        : drop all in-flight responses and the current request
//   ld_wen/ld_addr/ld_wdata : backdoor program-load write port
//   fetch_cnt    : number of cycles with exIns_valid=1 (wraps)
module exins_responder
  import exins_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 2048,
  parameter int unsigned LAT         = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exIns_ren,
  input  logic [31:0] exIns_addr,
  output logic        exIns_valid,
  output logic [31:0] exIns_data,
  output logic        exIns_err,
  input  logic        flush,
  input  logic        ld_wen,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  output logic [31:0] fetch_cnt
);

  localparam int unsigned AW    = addr_width(DEPTH_WORDS);
  localparam int unsigned RSP_W = $bits(ins_rsp_t);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] ld_idx;
  logic          rd_err;
  logic          ld_ok;
  logic [31:0]   rd_word;

  logic          s1_valid;
  ins_rsp_t      s1_rsp;
  ins_rsp_t      out_rsp;

  assign rd_idx = exIns_addr[AW+1:2];
  assign ld_idx = ld_addr[AW+1:2];
  assign rd_err = (exIns_addr[31:AW+2] != '0) || (exIns_addr[1:0] != 2'b00);
  assign ld_ok  = ld_wen && (ld_addr[31:AW+2] == '0) && (ld_addr[1:0] == 2'b00);

  // Write-first: a same-cycle load to the fetched word is forwarded.
  assign rd_word = (ld_ok && (ld_idx == rd_idx)) ? ld_wdata : mem[rd_idx];

  always_ff @(posedge clk) begin
    if (ld_ok) mem[ld_idx] <= ld_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_rsp   <= '0;
    end else begin
      s1_valid <= exIns_ren && !flush;
      if (exIns_ren && !flush) begin
        s1_rsp.err  <= rd_err;
        s1_rsp.data <= rd_err ? INS_NOP : rd_word;
      end
    end
  end

  if (LAT == 1) begin : g_no_delay
    assign exIns_valid = s1_valid;
    assign out_rsp     = s1_rsp;
  end else begin : g_delay
    logic [RSP_W-1:0] dl_data;

    exins_delay_line #(
      .WIDTH (RSP_W),
      .DEPTH (LAT - 1)
    ) u_delay (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (s1_valid),
      .in_data   (s1_rsp),
      .out_valid (exIns_valid),
      .out_data  (dl_data)
    );

    assign out_rsp = dl_data;
  end

  assign exIns_err  = out_rsp.err;
  assign exIns_data = out_rsp.data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fetch_cnt <= '0;
    else if (exIns_valid) fetch_cnt <= fetch_cnt + 32'd1;
  end

endmodule

// File: tb/tb_exins_responder.sv
module tb_exins_responder;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 2048;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exIns_ren = 1'b0;
  logic [31:0] exIns_addr = '0;
  logic        exIns_valid;
  logic [31:0] exIns_data;
  logic        exIns_err;
  logic        flush = 1'b0;
  logic        ld_wen = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [31:0] ld_wdata = '0;
  logic [31:0] fetch_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  exins_responder #(.DEPTH_WORDS(DEPTH), .LAT(LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .exIns_ren   (exIns_ren),
    .exIns_addr  (exIns_addr),
    .exIns_valid (exIns_valid),
    .exIns_data  (exIns_data),
    .exIns_err   (exIns_err),
    .flush       (flush),
    .ld_wen      (ld_wen),
    .ld_addr     (ld_addr),
    .ld_wdata    (ld_wdata),
    .fetch_cnt   (fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int unsigned due;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  rsp_t        q[$];
  logic [31:0] mem_m [DEPTH];
  int unsigned edge_n    = 0;
  int unsigned delivered = 0;
  logic [31:0] held_d    = '0;
  logic        held_e    = 1'b0;
  logic [31:0] cnt_bias   = '0;
  logic [31:0] cnt_anchor = '0;

  function automatic bit addr_ok(input logic [31:0] a);
    return (a < DEPTH * 4) && (a % 4 == 0);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      delivered = 0;
      held_d = '0;
      held_e = 1'b0;
    end else begin
      rsp_t r;
      if (q.size() > 0 && q[0].due == edge_n) begin
        held_d = q[0].data;
        held_e = q[0].err;
        void'(q.pop_front());
        delivered++;
      end
      edge_n++;
      if (flush) begin
        q.delete();
      end else if (exIns_ren) begin
        r.due = edge_n + LAT - 1;
        if (!addr_ok(exIns_addr)) begin
          r.err = 1'b1;
          r.data = 32'h0000_0013;
        end else begin
          r.err = 1'b0;
          if (ld_wen && addr_ok(ld_addr) && ld_addr == exIns_addr) r.data = ld_wdata;
          else r.data = mem_m[exIns_addr / 4];
        end
        q.push_back(r);
      end
      if (ld_wen && addr_ok(ld_addr)) mem_m[ld_addr / 4] = ld_wdata;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_valid", 32'(exIns_valid), 32'd0);
      chk("rst_cnt", fetch_cnt, 32'd0);
      chk("rst_data", exIns_data, 32'd0);
    end else begin
      bit          ev;
      logic [31:0] ed;
      logic        ee;
      ev = (q.size() > 0) && (q[0].due == edge_n);
      ed = ev ? q[0].data : held_d;
      ee = ev ? q[0].err : held_e;
      chk("valid", 32'(exIns_valid), 32'(ev));
      chk("data", exIns_data, ed);
      chk("err", 32'(exIns_err), 32'(ee));
      chk("fetch_cnt", fetch_cnt, 32'(delivered) - cnt_anchor + cnt_bias);
    end
  end

  // ---------------- stimulus ----------------
  task automatic load(input logic [31:0] a, input logic [31:0] d);
    ld_wen = 1'b1; ld_addr = a; ld_wdata = d;
    @(negedge clk);
    ld_wen = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    exIns_ren = 1'b1; exIns_addr = a;
    @(negedge clk);
  endtask

  task automatic idle(input int unsigned n);
    exIns_ren = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("init_valid", 32'(exIns_valid), 32'd0);
    chk("init_cnt", fetch_cnt, 32'd0);
    rst = 1'b0;

    // program image
    load(32'h0, 32'h11);
    load(32'h4, 32'h22);
    load(32'h8, 32'h33);
    load(32'hC, 32'h44);
    load(32'h10, 32'h55);

    // 1: back-to-back fetches
    fetch(32'h0); fetch(32'h4); fetch(32'h8); fetch(32'hC);
    idle(4);
    chk("t1_cnt", fetch_cnt, 32'd4);
    chk("t1_last", exIns_data, 32'h44);
    chk("t1_err", 32'(exIns_err), 32'd0);

    // 2: misaligned and out-of-range
    fetch(32'h0000_0002); fetch(32'h0000_2000);
    idle(4);
    chk("t2_cnt", fetch_cnt, 32'd6);
    chk("t2_nop", exIns_data, 32'h13);
    chk("t2_err", 32'(exIns_err), 32'd1);

    // 3: flush on the third request
    fetch(32'h0); fetch(32'h4);
    flush = 1'b1; exIns_ren = 1'b1; exIns_addr = 32'h8;
    @(negedge clk);
    flush = 1'b0;
    idle(4);
    chk("t3_cnt", fetch_cnt, 32'd7);
    chk("t3_data", exIns_data, 32'h11);

    // stray loads must be ignored (0x2010 would alias word 4)
    load(32'h0000_2010, 32'hBAD0_BAD0);
    load(32'h0000_0011, 32'hBAD1_BAD1);
    fetch(32'h10);
    idle(4);
    chk("stray_ld", exIns_data, 32'h55);

    // 4: same-cycle load/fetch collision
    ld_wen = 1'b1; ld_addr = 32'h10; ld_wdata = 32'hDEAD_BEEF;
    exIns_ren = 1'b1; exIns_addr = 32'h10;
    @(negedge clk);
    ld_wen = 1'b0;
    idle(4);
    chk("t4_bypass", exIns_data, 32'hDEAD_BEEF);
    fetch(32'h10);
    idle(4);
    chk("t4_kept", exIns_data, 32'hDEAD_BEEF);
    chk("t4_cnt", fetch_cnt, 32'd10);

    // 5: asynchronous reset mid-stream
    fetch(32'h0); fetch(32'h4); fetch(32'h8);
    chk("t5_pre_valid", 32'(exIns_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_valid", 32'(exIns_valid), 32'd0);
    chk("t5_cnt", fetch_cnt, 32'd0);
    chk("t5_data", exIns_data, 32'd0);
    chk("t5_err", 32'(exIns_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    fetch(32'h4);
    idle(4);
    chk("t5_refetch", exIns_data, 32'h22);
    chk("t5_cnt_after", fetch_cnt, 32'd1);

    // 6: counter wrap
    #1;
    force dut.fetch_cnt = 32'hFFFF_FFFE;
    cnt_anchor = 32'(delivered);
    cnt_bias   = 32'hFFFF_FFFE;
    #1;
    release dut.fetch_cnt;
    fetch(32'h0); fetch(32'h4); fetch(32'h8);
    exIns_ren = 1'b0;
    chk("t6_cnt0", fetch_cnt, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("t6_cnt1", fetch_cnt, 32'h0000_0000);
    @(negedge clk);
    chk("t6_cnt2", fetch_cnt, 32'h0000_0001);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
